// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment display driver.
// Segment patterns are {g,f,e,d,c,b,a}, active low.
package sseg_pkg;

    localparam int NUM_DIG = 3;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        S_D0 = 2'd0,
        S_D1 = 2'd1,
        S_D2 = 2'd2
    } scan_t;

endpackage

// File: rtl/sseg_mux_driver_dec.sv
// BCD to active-low seven-segment decoder.
// Non-BCD codes render as a dash so bad data is visible.
module bcd_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup; anything above 9 shows the middle bar only.
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sseg_mux_driver.sv
// Three-digit multiplexed common-anode display driver with
// snapshot, anti-ghost blanking and leading-zero suppression.
module sseg_mux_driver
    import sseg_pkg::*;
#(
    parameter int DVSR      = 100000,
    parameter int BLANK_CYC = 4,
    parameter int DP_POS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       load,
    input  logic       blank_lz,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = $clog2(DVSR);
    localparam logic [CW-1:0] CNT_MAX = CW'(DVSR - 1);
    localparam logic [CW-1:0] BLK     = CW'(BLANK_CYC);
    localparam logic [1:0]    DPS     = 2'(DP_POS);

    logic [CW-1:0]              cnt;
    logic                       tick;
    scan_t                      state;
    scan_t                      state_nx;
    logic [1:0]                 sel;
    logic [NUM_DIG-1:0][3:0]    sh;
    logic [3:0]                 cur;
    logic [6:0]                 cur_seg;
    logic                       lz;
    logic                       active;
    logic [2:0]                 an_nx;
    logic [6:0]                 seg_nx;
    logic                       dp_nx;

    assign tick = (cnt == CNT_MAX);
    assign sel  = state;

    // Slot timer: one full period per digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

    // Scan state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_D0;
        else        state <= state_nx;
    end

    // Rotate through the digits at the end of each slot.
    always_comb begin
        state_nx = state;
        if (tick) begin
            case (state)
                S_D0:    state_nx = S_D1;
                S_D1:    state_nx = S_D2;
                default: state_nx = S_D0;
            endcase
        end
    end

    // Snapshot: only a load strobe lets new digits reach the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else if (load) begin
            sh[2] <= d2;
            sh[1] <= d1;
            sh[0] <= d0;
        end
    end

    // Pick the digit for the current slot and decide if it is hidden.
    always_comb begin
        cur = sh[0];
        lz  = 1'b0;
        case (state)
            S_D1: begin
                cur = sh[1];
                lz  = blank_lz && (DPS < 2'd1)
                      && (sh[2] == 4'd0) && (sh[1] == 4'd0);
            end
            S_D2: begin
                cur = sh[2];
                lz  = blank_lz && (DPS < 2'd2) && (sh[2] == 4'd0);
            end
            default: begin
                cur = sh[0];
                lz  = 1'b0;
            end
        endcase
    end

    bcd_to_sseg u_dec (
        .bcd (cur),
        .seg (cur_seg)
    );

    // Next pin values; anodes stay off during the blanking window.
    always_comb begin
        active = (cnt >= BLK) && !lz;
        an_nx  = active ? ~(3'b001 << sel) : 3'b111;
        seg_nx = active ? cur_seg : SEG_OFF;
        dp_nx  = ~(active && (sel == DPS));
    end

    // Registered pins so no decode glitches reach the board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 3'b111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_nx;
            seg <= seg_nx;
            dp  <= dp_nx;
        end
    end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Self-checking bench for sseg_mux_driver: cycle scoreboard
// plus frame-level vector table and hand-written corner cases.
module tb_sseg_mux_driver;

    localparam int DVSR = 8;
    localparam int BLK  = 2;
    localparam int DPP  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d2 = '0, d1 = '0, d0 = '0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sseg_mux_driver #(
        .DVSR      (DVSR),
        .BLANK_CYC (BLK),
        .DP_POS    (DPP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d2       (d2),
        .d1       (d1),
        .d0       (d0),
        .load     (load),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    typedef struct packed {
        logic [2:0] an;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    out_t       exp_q[$];
    int         m_cnt;
    int         m_sel;
    logic [3:0] m_sh[3];

    // Reference model: expected pins for this edge go to the queue.
    always @(posedge clk or negedge rst_n) begin
        out_t e;
        logic act;
        logic lzb;
        if (!rst_n) begin
            m_cnt <= 0;
            m_sel <= 0;
            m_sh[0] <= '0;
            m_sh[1] <= '0;
            m_sh[2] <= '0;
            exp_q.delete();
        end else begin
            lzb = blank_lz && (m_sel > DPP);
            for (int k = 0; k < 3; k++)
                if (k >= m_sel && m_sh[k] != 4'd0) lzb = 1'b0;
            act = (m_cnt >= BLK) && !lzb;
            e.an = 3'b111;
            if (act) e.an[m_sel] = 1'b0;
            e.seg = act ? ref_dec(m_sh[m_sel]) : 7'h7F;
            e.dp = !(act && m_sel == DPP);
            exp_q.push_back(e);
            if (m_cnt == DVSR - 1) begin
                m_cnt <= 0;
                m_sel <= (m_sel + 1) % 3;
            end else begin
                m_cnt <= m_cnt + 1;
            end
            if (load) begin
                m_sh[2] <= d2;
                m_sh[1] <= d1;
                m_sh[0] <= d0;
            end
        end
    end

    // Compare pins against the model away from the rising edge.
    always @(negedge clk) begin
        out_t e;
        if (!rst_n) begin
            chk("rst_pins", {an, seg, dp}, {3'b111, 7'h7F, 1'b1});
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pins", {an, seg, dp}, e);
            chk("onehot", ($countones(~an) <= 1), 1);
        end
    end

    task automatic frame(input string nm, input logic [6:0] e0,
                         input logic [6:0] e1, input logic [6:0] e2,
                         input logic show2);
        logic [2:0][6:0] s;
        logic [2:0]      dpv;
        logic [2:0]      seen;
        seen = '0;
        s = '0;
        dpv = '1;
        repeat (3 * DVSR) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (an[k] == 1'b0) begin
                    seen[k] = 1'b1;
                    s[k] = seg;
                    dpv[k] = dp;
                end
            end
        end
        chk({nm, "_seen"}, seen, {show2, 2'b11});
        chk({nm, "_s0"}, s[0], e0);
        chk({nm, "_s1"}, s[1], e1);
        if (show2) chk({nm, "_s2"}, s[2], e2);
        chk({nm, "_dp"}, dpv, 3'b101);
    endtask

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c);
        @(negedge clk);
        d2 = a;
        d1 = b;
        d0 = c;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_an(input string nm, input logic [2:0] v);
        int t;
        t = 0;
        while (an !== v && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk(nm, (t < 100), 1);
    endtask

    typedef struct {
        logic [3:0] d2, d1, d0;
        logic       blz;
        logic [6:0] s0, s1, s2;
        logic       show2;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic [2:0] rel[11];

        vt[0] = '{4'd1, 4'd2, 4'd3, 1'b0, 7'h30, 7'h24, 7'h79, 1'b1};
        vt[1] = '{4'd0, 4'd0, 4'd5, 1'b1, 7'h12, 7'h40, 7'h7F, 1'b0};
        vt[2] = '{4'd0, 4'd0, 4'd5, 1'b0, 7'h12, 7'h40, 7'h40, 1'b1};
        vt[3] = '{4'd1, 4'd2, 4'hC, 1'b0, 7'h3F, 7'h24, 7'h79, 1'b1};
        vt[4] = '{4'd4, 4'd5, 4'd6, 1'b0, 7'h02, 7'h12, 7'h19, 1'b1};
        vt[5] = '{4'd7, 4'd8, 4'd9, 1'b0, 7'h10, 7'h00, 7'h78, 1'b1};
        vt[6] = '{4'd0, 4'd7, 4'd0, 1'b1, 7'h40, 7'h78, 7'h7F, 1'b0};
        vt[7] = '{4'd5, 4'd0, 4'd0, 1'b1, 7'h40, 7'h40, 7'h12, 1'b1};
        vt[8] = '{4'hF, 4'hA, 4'hB, 1'b0, 7'h3F, 7'h3F, 7'h3F, 1'b1};

        rel[0] = 3'b111;
        rel[1] = 3'b111;
        for (int i = 2; i < 8; i++) rel[i] = 3'b110;
        rel[8] = 3'b111;
        rel[9] = 3'b111;
        rel[10] = 3'b101;

        // Reset hold and release timing.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hold", {an, seg, dp}, {3'b111, 7'h7F, 1'b1});
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("rel_an", an, rel[i]);
        end

        // Frame-level vectors.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            blank_lz = vt[i].blz;
            do_load(vt[i].d2, vt[i].d1, vt[i].d0);
            frame("vec", vt[i].s0, vt[i].s1, vt[i].s2, vt[i].show2);
        end

        // Inputs change without load: display must not follow.
        blank_lz = 1'b0;
        do_load(4'd1, 4'd2, 4'd3);
        d2 = 4'd9;
        d1 = 4'd9;
        d0 = 4'd9;
        frame("hold", 7'h30, 7'h24, 7'h79, 1'b1);
        do_load(4'd9, 4'd9, 4'd9);
        frame("reload", 7'h10, 7'h10, 7'h10, 1'b1);

        // Asynchronous reset in the middle of slot 1.
        wait_an("wait_s1", 3'b101);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {an, seg, dp}, {3'b111, 7'h7F, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        wait_an("wait_post_s0", 3'b110);
        chk("post_s0", {seg, dp}, {7'h40, 1'b1});
        wait_an("wait_post_s1", 3'b101);
        chk("post_s1", {seg, dp}, {7'h40, 1'b0});
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
